serial_negate_unit: RTL

SERIAL_NEGATE_UNIT -- requirements
Module: serial_negate_unit

---
 rtl/serial_negate_pkg.sv | 33 +++
 rtl/negate_digit.sv | 26 ++
 rtl/serial_negate_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_negate_pkg.sv
// Shared types for the serial negate unit: mode encodings, FSM states and
// the per-operand invert/carry selection rules.
package serial_negate_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Absolute value only flips negative operands, so it borrows the sign bit.
    function automatic logic mode_invert(input logic [1:0] mode, input logic sign);
        case (mode)
            MODE_ONES, MODE_NEG: mode_invert = 1'b1;
            MODE_ABS:            mode_invert = sign;
            default:             mode_invert = 1'b0;
        endcase
    endfunction

    function automatic logic mode_carry(input logic [1:0] mode, input logic sign);
        case (mode)
            MODE_NEG: mode_carry = 1'b1;
            MODE_ABS: mode_carry = sign;
            default:  mode_carry = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/negate_digit.sv
// One digit of the serial datapath: (digit XOR invert) + carry_in through a
// ripple of 1-bit full-adder cells whose second addend is tied low.
module negate_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] digit,
    input  logic             invert,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out
);

    logic [DIGIT:0]   carry;
    logic [DIGIT-1:0] addend;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign addend[i]  = digit[i] ^ invert;
        assign sum[i]     = addend[i] ^ 1'b0 ^ carry[i];
        assign carry[i+1] = (addend[i] & 1'b0) | (addend[i] & carry[i]) | (1'b0 & carry[i]);
    end

    assign carry_out = carry[DIGIT];

endmodule

// File: rtl/serial_negate_unit.sv
// Digit-serial pass / ones-complement / negate / absolute-value unit with a
// valid/ready handshake on both sides; one DIGIT-wide slice per CALC cycle.
module serial_negate_unit
    import serial_negate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_negate_unit: WIDTH must be a multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               invert_q, invert_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               live_q;

    logic [DIGIT-1:0]   digit_in;
    logic [DIGIT-1:0]   digit_sum;
    logic               digit_cout;

    assign digit_in = operand_q[int'(idx_q) * DIGIT +: DIGIT];

    negate_digit #(.DIGIT(DIGIT)) u_digit (
        .digit     (digit_in),
        .invert    (invert_q),
        .carry_in  (carry_q),
        .sum       (digit_sum),
        .carry_out (digit_cout)
    );

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = (state_q == IDLE) && live_q;
    assign out_valid = (state_q == DONE);
    assign out_y     = result_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        idx_d     = idx_q;
        invert_d  = invert_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    operand_d = in_a;
                    idx_d     = '0;
                    invert_d  = mode_invert(in_mode, in_a[WIDTH-1]);
                    carry_d   = mode_carry(in_mode, in_a[WIDTH-1]);
                    ovf_d     = ((in_mode == MODE_NEG) || (in_mode == MODE_ABS)) && (in_a == MIN_VAL);
                    state_d   = CALC;
                end
            end
            CALC: begin
                result_d[int'(idx_q) * DIGIT +: DIGIT] = digit_sum;
                carry_d = digit_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            invert_q  <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            operand_q <= operand_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
            invert_q  <= invert_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            live_q    <= 1'b1;
        end
    end

endmodule
